// File: rtl/fx_pt_add_pipe.sv
// Two-stage pipelined fixed-point add/subtract with operand alignment to a common
// full-precision format; valid/ready on both sides, one result per cycle.
module fx_pt_add_pipe #(
    parameter  int WIDTH   = 8,
    parameter  int A_INT_W = 4,
    parameter  int B_INT_W = 4,
    parameter  int MODE    = 1,
    localparam int FA      = WIDTH - A_INT_W,
    localparam int FB      = WIDTH - B_INT_W,
    localparam int F       = (FA > FB) ? FA : FB,
    localparam int I       = ((A_INT_W > B_INT_W) ? A_INT_W : B_INT_W) + 1,
    localparam int OUT_W   = I + F
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] sum,
    output logic             borrow
);

    localparam int SH_A = F - FA;
    localparam int SH_B = F - FB;

    if (MODE < 0 || MODE > 2) begin : g_bad_mode
        $error("fx_pt_add_pipe: MODE must be 0, 1 or 2");
    end

    // One guard bit above OUT_W so every aligned operand and its negation is exact.
    typedef logic signed [OUT_W:0] acc_t;

    function automatic acc_t align(input logic [WIDTH-1:0] x, input int sh);
        acc_t v;
        acc_t m;
        v = '0;
        m = '0;
        if (MODE == 0) begin
            v = $signed({{(OUT_W+1-WIDTH){1'b0}}, x}) << sh;
        end else if (MODE == 1) begin
            v = $signed({{(OUT_W+1-WIDTH){x[WIDTH-1]}}, x}) << sh;
        end else begin
            m = $signed({{(OUT_W+2-WIDTH){1'b0}}, x[WIDTH-2:0]}) << sh;
            v = x[WIDTH-1] ? -m : m;
        end
        return v;
    endfunction

    acc_t s1_a, s1_b;
    logic s1_valid, s2_valid;
    logic s1_adv, s2_adv, accept;

    acc_t             s2_res;
    logic [OUT_W-1:0] res_sum;
    logic             res_bw;
    logic [OUT_W-2:0] mag;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = s1_valid && s2_adv;
    assign in_ready  = !rst && (!s1_valid || s2_adv);
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_valid;

    // A zero result is non-negative, so sign-magnitude never emits -0.
    always_comb begin
        s2_res  = s1_a + s1_b;
        mag     = (OUT_W-1)'(s2_res[OUT_W] ? -s2_res : s2_res);
        res_sum = s2_res[OUT_W-1:0];
        res_bw  = 1'b0;
        if (MODE == 0) res_bw = s2_res[OUT_W];
        if (MODE == 2) res_sum = {s2_res[OUT_W], mag};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            sum      <= '0;
            borrow   <= 1'b0;
        end else begin
            if (accept) begin
                s1_a     <= align(a, SH_A);
                s1_b     <= op ? -align(b, SH_B) : align(b, SH_B);
                s1_valid <= 1'b1;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
            if (s2_adv) s2_valid <= s1_valid;
            // Output data only moves with a real transfer so it holds while idle.
            if (s1_adv) begin
                sum    <= res_sum;
                borrow <= res_bw;
            end
        end
    end

endmodule

// File: tb/tb_fx_pt_add_pipe.sv
// Scoreboard bench: four parameterisations share one stimulus stream and are
// checked against an integer-arithmetic reference model.
module tb_fx_pt_add_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       op = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       out_ready = 1'b1;

    wire [3:0] rdy, ov, bw;
    wire [8:0] s0, s1, s2;
    wire [12:0] s3;
    wire [3:0][15:0] sums = {{3'b0, s3}, {7'b0, s2}, {7'b0, s1}, {7'b0, s0}};

    always #5 clk = ~clk;

    fx_pt_add_pipe #(.WIDTH(8), .A_INT_W(4), .B_INT_W(4), .MODE(0)) u_d0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .op(op), .a(a), .b(b),
        .out_valid(ov[0]), .out_ready(out_ready), .sum(s0), .borrow(bw[0]));
    fx_pt_add_pipe #(.WIDTH(8), .A_INT_W(4), .B_INT_W(4), .MODE(1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .op(op), .a(a), .b(b),
        .out_valid(ov[1]), .out_ready(out_ready), .sum(s1), .borrow(bw[1]));
    fx_pt_add_pipe #(.WIDTH(8), .A_INT_W(4), .B_INT_W(4), .MODE(2)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .op(op), .a(a), .b(b),
        .out_valid(ov[2]), .out_ready(out_ready), .sum(s2), .borrow(bw[2]));
    fx_pt_add_pipe #(.WIDTH(8), .A_INT_W(6), .B_INT_W(2), .MODE(1)) u_d3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[3]), .op(op), .a(a), .b(b),
        .out_valid(ov[3]), .out_ready(out_ready), .sum(s3), .borrow(bw[3]));

    typedef struct packed {
        logic [3:0][15:0] s;
        logic [3:0]       bw;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic rst_q = 1'b1;
    logic stall_prev = 1'b0;
    logic saw_block = 1'b0;
    logic done = 1'b0;
    logic [3:0][15:0] held_s;
    logic [3:0]       held_bw;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Operand value in units of 2^-f, straight from the number-format definition.
    function automatic longint dec(input logic [7:0] x, input int mode, input int iw, input int f);
        longint v;
        case (mode)
            0:       v = longint'(x);
            1:       v = longint'($signed(x));
            default: v = x[7] ? -longint'(x[6:0]) : longint'(x[6:0]);
        endcase
        return v * (longint'(1) << (f - (8 - iw)));
    endfunction

    function automatic void model(input int k, input logic [7:0] ta, input logic [7:0] tv,
                                  input logic top, output logic [15:0] s, output logic bo);
        int mode, aiw, biw, f, ow;
        longint r, m;
        mode = (k == 3) ? 1 : k;
        aiw  = (k == 3) ? 6 : 4;
        biw  = (k == 3) ? 2 : 4;
        f    = ((8 - aiw) > (8 - biw)) ? 8 - aiw : 8 - biw;
        ow   = ((aiw > biw) ? aiw : biw) + 1 + f;
        r    = top ? dec(ta, mode, aiw, f) - dec(tv, mode, biw, f)
                   : dec(ta, mode, aiw, f) + dec(tv, mode, biw, f);
        bo   = (mode == 0) && (r < 0);
        if (mode == 2) begin
            m = (r < 0) ? -r : r;
            s = 16'(((r < 0) ? (longint'(1) << (ow - 1)) : 0) | m);
        end else begin
            s = 16'(r & ((longint'(1) << ow) - 1));
        end
    endfunction

    always @(posedge clk) begin
        cyc++;
        rst_q = rst;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_q) begin
            for (int k = 0; k < 4; k++) begin
                chk("reset out_valid", 16'(ov[k]), 16'd0);
                chk("reset sum", sums[k], 16'd0);
                chk("reset borrow", 16'(bw[k]), 16'd0);
            end
        end
        if (rst) begin
            chk("in_ready during reset", 16'(rdy), 16'd0);
            q.delete();
            stall_prev = 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                chk("in_ready agree", 16'(rdy[k]), 16'(rdy[1]));
                chk("out_valid agree", 16'(ov[k]), 16'(ov[1]));
                if (stall_prev) begin
                    chk("stall out_valid", 16'(ov[k]), 16'd1);
                    chk("stall sum", sums[k], held_s[k]);
                    chk("stall borrow", 16'(bw[k]), 16'(held_bw[k]));
                end
            end
            if (ov[1] && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected result", 16'(ov[1]), 16'd0);
                end else begin
                    e = q.pop_front();
                    for (int k = 0; k < 4; k++) begin
                        chk($sformatf("sum dut%0d", k), sums[k], e.s[k]);
                        chk($sformatf("borrow dut%0d", k), 16'(bw[k]), 16'(e.bw[k]));
                    end
                end
            end
            stall_prev = ov[1] && !out_ready;
            held_s     = sums;
            held_bw    = bw;
            if (in_valid && !rdy[1]) saw_block = 1'b1;
            if (in_valid && rdy[1]) begin
                for (int k = 0; k < 4; k++) begin
                    logic [15:0] es;
                    logic eb;
                    model(k, a, b, op, es, eb);
                    e.s[k]  = es;
                    e.bw[k] = eb;
                end
                q.push_back(e);
                chk("pending <= 2", 16'(q.size() <= 2), 16'd1);
            end
        end
    end

    // Holds in_valid until accepted; caller decides when to drop it.
    task automatic drive(input logic [7:0] ta, input logic [7:0] tv, input logic top, output int edges);
        logic acc;
        edges = 0;
        acc = 1'b0;
        a = ta; b = tv; op = top; in_valid = 1'b1;
        while (!acc && edges < 60) begin
            @(negedge clk);
            acc = rdy[1];
            @(posedge clk);
            #1;
            edges++;
        end
        chk("accept within bound", 16'(acc), 16'd1);
    endtask

    task automatic send_one(input logic [7:0] ta, input logic [7:0] tv, input logic top);
        int e, n;
        drive(ta, tv, top, e);
        in_valid = 1'b0;
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (ov[1]) break;
        end
        chk("latency", 16'(n), 16'd2);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drained", 16'(q.size()), 16'd0);
    endtask

    initial begin
        int e, tot;
        // in_valid high during reset must be ignored
        in_valid = 1'b1; a = 8'h18; b = 8'h18;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready after reset", 16'(rdy[1]), 16'd1);
        @(posedge clk);
        #1;

        // directed vectors from the number-format examples
        send_one(8'h18, 8'hF8, 1'b0);
        send_one(8'h18, 8'hF8, 1'b1);
        send_one(8'h98, 8'h18, 1'b0);
        send_one(8'h90, 8'h08, 1'b0);
        send_one(8'h10, 8'h20, 1'b1);
        send_one(8'h10, 8'h20, 1'b0);
        send_one(8'h04, 8'h40, 1'b0);
        send_one(8'h80, 8'h00, 1'b1);
        send_one(8'h7F, 8'h80, 1'b1);

        // backpressure: 5 back-to-back pairs, out_ready low for cycles 2-5
        saw_block = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) drive(8'($urandom), 8'($urandom), 1'($urandom), e);
                in_valid = 1'b0;
            end
            begin
                out_ready = 1'b1;
                @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        chk("in_ready dropped under stall", 16'(saw_block), 16'd1);
        drain();

        // full throughput: 8 pairs in 8 edges with out_ready high
        tot = 0;
        for (int i = 0; i < 8; i++) begin
            drive(8'($urandom), 8'($urandom), 1'($urandom), e);
            tot += e;
        end
        in_valid = 1'b0;
        chk("throughput edges", 16'(tot), 16'd8);
        drain();

        // randomized traffic with random backpressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    drive(8'($urandom), 8'($urandom), 1'($urandom), e);
                end
                in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(2) != 0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        drain();

        // reset with two operations in flight
        drive(8'h21, 8'h13, 1'b0, e);
        drive(8'h35, 8'h07, 1'b1, e);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("in_ready after mid reset", 16'(rdy[1]), 16'd1);
        repeat (4) @(posedge clk);
        #1;
        send_one(8'h18, 8'hF8, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required finish before %0t", $time);
        $fatal(1);
    end

endmodule
